mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 5: memory address width.
REQ-002 SHALL have parameter DW, default 8: memory data width.
REQ-003 SHALL have parameter MEM_LAT, default 1: memory access cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports cpu_req / ld_req, input, 1: access request from the CPU / program-loader port.
REQ-007 SHALL have ports cpu_wr / ld_wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have ports cpu_addr / ld_addr, input, AW: access address.
REQ-009 SHALL have ports cpu_wdata / ld_wdata, input, DW: write data.
REQ-010 SHALL have ports cpu_gnt / ld_gnt, output, 1: requester owns the memory.
REQ-011 SHALL have ports cpu_done / ld_done, output, 1: single-cycle access-complete pulse.
REQ-012 SHALL have ports cpu_rdata / ld_rdata, output, DW: registered read data.
REQ-013 SHALL have ports mem_rd / mem_wr, output, 1: memory strobes.
REQ-014 SHALL have port mem_addr, output, AW, and port mem_wdata, output, DW: memory address and write data.
REQ-015 SHALL have port mem_rdata, input, DW: memory read data.
REQ-016 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE -> ACCESS -> DONE -> IDLE.
REQ-018 IDLE, any req high at edge T: SHALL latch the winner's wr/addr/wdata and enter ACCESS at T+1.
REQ-019 ACCESS: SHALL drive gnt of the winner, mem_addr, mem_wdata, and mem_rd or mem_wr, for exactly MEM_LAT cycles (T+1..T+MEM_LAT), using an internal latency counter.
REQ-020 SHALL capture mem_rdata on a read at the end of cycle T+MEM_LAT.
REQ-021 DONE (T+MEM_LAT+1): SHALL assert done of the winner and hold its gnt; mem_rd and mem_wr SHALL be 0.
REQ-022 SHALL hold rdata of the winner valid from DONE until that requester's next read completes; writes SHALL leave rdata unchanged.
REQ-023 Both req high in IDLE: SHALL grant round-robin, the requester not granted last winning.
REQ-024 SHALL keep all outputs registered, with no combinational path from any req to any gnt.
REQ-025 Req dropped during ACCESS: SHALL complete the access without aborting; done still pulses.
REQ-026 Requests arriving during ACCESS/DONE: SHALL be ignored until IDLE; minimum spacing is MEM_LAT+2 cycles per access.
REQ-027 gnt SHALL be one-hot or zero; cpu_gnt and ld_gnt SHALL never be high together.
REQ-028 Address and data widths SHALL pass through unmodified, with no address arithmetic.

Reset
REQ-029 rst high at an edge: SHALL set the state to IDLE and the latency counter to 0, and clear every output, including rdata, to 0.
REQ-030 Reset SHALL set the round-robin pointer to "last = loader", so the CPU wins the first tie.
REQ-031 Reset during ACCESS: SHALL abort the access, drop strobes in the next cycle and emit no done.

Configuration
REQ-032 SHALL define macro MEM_ARB_LD_PRIO_EN so that, when defined, ld_req has fixed priority over cpu_req on ties.
REQ-033 Without MEM_ARB_LD_PRIO_EN, SHALL use round-robin per REQ-023.

Structure
REQ-034 SHALL place the FSM state enum, requester-ID constants (CPU = 0, LD = 1) and the AW/DW defaults in package mem_arb_pkg.
REQ-035 SHALL implement the winner select as sub-module arb_rr2: 2-way picker holding the last-grant pointer and honouring MEM_ARB_LD_PRIO_EN.

Verification
REQ-036 SHALL test a single CPU read: MEM_LAT = 1, addr 5'h03, memory holds 8'hA5 -> cpu_gnt cycles T+1..T+2, mem_rd at T+1, cpu_done at T+2, cpu_rdata = 8'hA5.
REQ-037 SHALL test a loader write: ld_wr = 1, addr 5'h1F, data 8'h3C, MEM_LAT = 3 -> mem_wr high for exactly 3 cycles, ld_done at T+4, and a later read returns 8'h3C.
REQ-038 SHALL test a tie with round-robin: both req held high continuously -> grants alternate CPU, LD, CPU, LD, each spaced MEM_LAT+2 cycles.
REQ-039 SHALL test a tie with MEM_ARB_LD_PRIO_EN defined: both req held high -> ld_gnt every time and the CPU starved.
REQ-040 SHALL test reset mid-access: rst at the second ACCESS cycle (MEM_LAT = 3) -> strobes are 0 in the next cycle, no done, busy = 0, and the CPU wins the next tie.
REQ-041 SHALL test a dropped request: cpu_req deasserted at T+1 -> the access completes, cpu_done pulses once, and no second access starts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Build option: MEM_ARB_LD_PRIO_EN (see arb_rr2) gives the loader fixed
// priority on ties. Without it, ties alternate round-robin.
package mem_arb_pkg;

  localparam int AW_DEFAULT  = 5;
  localparam int DW_DEFAULT  = 8;

  // Access latency is 1..4 cycles, so the down-counter needs to hold 0..3.
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = 2;

  typedef logic req_id_t;
  localparam req_id_t ID_CPU = 1'b0;
  localparam req_id_t ID_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  // Reload value for the latency down-counter: it reaches terminal count
  // (zero) on the last strobe cycle.
  function automatic logic [LAT_CNT_W-1:0] lat_load(input int lat);
    return LAT_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way winner select between CPU and program loader.
// Holds the last-grant pointer; reset makes the loader "last" so the CPU
// wins the first tie.
// Build option: MEM_ARB_LD_PRIO_EN -> loader always wins ties.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cpu_req,
  input  logic    ld_req,
  input  logic    take,
  output logic    any_req,
  output req_id_t winner
);

  req_id_t last;

  assign any_req = cpu_req | ld_req;

  // Pointer advances only when the FSM actually starts an access.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ID_LD;
    end else if (take) begin
      last <= winner;
    end
  end

  // Winner select; with no request the value is a don't-care.
  always_comb begin
`ifdef MEM_ARB_LD_PRIO_EN
    winner = ld_req ? ID_LD : (cpu_req ? ID_CPU : last);
`else
    winner = last;
    if (cpu_req && ld_req) begin
      winner = (last == ID_CPU) ? ID_LD : ID_CPU;
    end else if (cpu_req) begin
      winner = ID_CPU;
    end else if (ld_req) begin
      winner = ID_LD;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (CPU and program loader).
// One access at a time: IDLE -> ACCESS (MEM_LAT cycles) -> DONE -> IDLE.
// Every output is registered; grants never depend combinationally on req.
// Build option: MEM_ARB_LD_PRIO_EN -> loader has fixed priority on ties.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no owner; sample requests and pick a winner
//   ST_ACCESS | strobes driven, latency counter running down to zero
//   ST_DONE   | done pulse, grant held, strobes low; back to IDLE next
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int MEM_LAT = 1            // legal range 1..MEM_LAT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          ld_req,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          ld_gnt,
  output logic          ld_done,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t           state;
  logic [LAT_CNT_W-1:0] lat_cnt;
  req_id_t              owner;
  logic                 wr_q;

  logic                 any_req;
  req_id_t              winner;
  logic                 take;
  logic                 sel_wr;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

  assign take      = (state == ST_IDLE) && any_req;
  assign sel_wr    = (winner == ID_LD) ? ld_wr    : cpu_wr;
  assign sel_addr  = (winner == ID_LD) ? ld_addr  : cpu_addr;
  assign sel_wdata = (winner == ID_LD) ? ld_wdata : cpu_wdata;

  arb_rr2 u_pick (
    .clk     (clk),
    .rst     (rst),
    .cpu_req (cpu_req),
    .ld_req  (ld_req),
    .take    (take),
    .any_req (any_req),
    .winner  (winner)
  );

  // Access sequencer: every output is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      owner     <= ID_CPU;
      wr_q      <= 1'b0;
      cpu_gnt   <= 1'b0;
      ld_gnt    <= 1'b0;
      cpu_done  <= 1'b0;
      ld_done   <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ld_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= winner;
            wr_q      <= sel_wr;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_rd    <= ~sel_wr;
            mem_wr    <= sel_wr;
            cpu_gnt   <= (winner == ID_CPU);
            ld_gnt    <= (winner == ID_LD);
            lat_cnt   <= lat_load(MEM_LAT);
            busy      <= 1'b1;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (lat_cnt == '0) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (!wr_q) begin
              if (owner == ID_CPU) cpu_rdata <= mem_rdata;
              else                 ld_rdata  <= mem_rdata;
            end
            cpu_done <= (owner == ID_CPU);
            ld_done  <= (owner == ID_LD);
            state    <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          cpu_gnt <= 1'b0;
          ld_gnt  <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT = 1 and 3) share one set of
// requester inputs, each with its own memory array. A transaction-schedule
// model predicts every output from each access's start cycle.
// Honours MEM_ARB_LD_PRIO_EN when the build defines it.
module tb_mem_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, ld_req, cpu_wr, ld_wr;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [DW-1:0] cpu_wdata, ld_wdata;

  logic [1:0] cpu_gnt, ld_gnt, cpu_done, ld_done, mem_rd, mem_wr, busy;
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic [DW-1:0] cpu_rdata [2];
  logic [DW-1:0] ld_rdata  [2];
  logic [DW-1:0] mem       [2][32];

  always #5 clk = ~clk;

  assign mem_rdata[0] = mem[0][mem_addr[0]];
  assign mem_rdata[1] = mem[1][mem_addr[1]];

  always @(posedge clk) begin
    if (mem_wr[0]) mem[0][mem_addr[0]] = mem_wdata[0];
    if (mem_wr[1]) mem[1][mem_addr[1]] = mem_wdata[1];
  end

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT0)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .cpu_gnt(cpu_gnt[0]), .cpu_done(cpu_done[0]), .cpu_rdata(cpu_rdata[0]),
    .ld_gnt(ld_gnt[0]), .ld_done(ld_done[0]), .ld_rdata(ld_rdata[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT1)) u_lat3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .cpu_gnt(cpu_gnt[1]), .cpu_done(cpu_done[1]), .cpu_rdata(cpu_rdata[1]),
    .ld_gnt(ld_gnt[1]), .ld_done(ld_done[1]), .ld_rdata(ld_rdata[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Reference model: one schedule entry per instance (start edge, owner, op).
  int            cyc;
  int            t_start [2];
  bit            t_wr    [2];
  bit            t_own   [2];
  logic [AW-1:0] t_addr  [2];
  logic [DW-1:0] t_wdata [2];
  bit            last_ld [2];
  logic [DW-1:0] ref_mem [2][32];
  logic [DW-1:0] e_rdata [2][2];

  int errors = 0;
  int checks = 0;
  int done_cnt [2];
  int wr_cyc   [2];
  bit track;
  bit prev_gc, prev_gl;
  bit seen_q [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the schedule at a rising edge using the inputs seen at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int lat = lat_of(k);
      int d   = cyc - t_start[k];
      if (t_wr[k] && d >= 1 && d <= lat) ref_mem[k][t_addr[k]] = t_wdata[k];
      if (rst) begin
        t_start[k]    = -100;
        last_ld[k]    = 1'b1;
        e_rdata[k][0] = '0;
        e_rdata[k][1] = '0;
      end else begin
        if (!t_wr[k] && d == lat) e_rdata[k][t_own[k]] = ref_mem[k][t_addr[k]];
        if (d >= lat + 2 && (cpu_req || ld_req)) begin
          bit own;
`ifdef MEM_ARB_LD_PRIO_EN
          own = ld_req;
`else
          if (cpu_req && ld_req) own = !last_ld[k];
          else                   own = ld_req;
`endif
          last_ld[k] = own;
          t_own[k]   = own;
          t_start[k] = cyc;
          t_wr[k]    = own ? ld_wr : cpu_wr;
          t_addr[k]  = own ? ld_addr : cpu_addr;
          t_wdata[k] = own ? ld_wdata : cpu_wdata;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int    lat = lat_of(k);
      int    d   = cyc - t_start[k];
      bit    acc = (d >= 0) && (d < lat);
      bit    dn  = (d == lat);
      string s   = (k == 0) ? "L1" : "L3";
      chk({s, ".cpu_gnt"},   cpu_gnt[k],   (acc || dn) && !t_own[k]);
      chk({s, ".ld_gnt"},    ld_gnt[k],    (acc || dn) &&  t_own[k]);
      chk({s, ".cpu_done"},  cpu_done[k],  dn && !t_own[k]);
      chk({s, ".ld_done"},   ld_done[k],   dn &&  t_own[k]);
      chk({s, ".mem_rd"},    mem_rd[k],    acc && !t_wr[k]);
      chk({s, ".mem_wr"},    mem_wr[k],    acc &&  t_wr[k]);
      chk({s, ".busy"},      busy[k],      acc || dn);
      chk({s, ".cpu_rdata"}, cpu_rdata[k], e_rdata[k][0]);
      chk({s, ".ld_rdata"},  ld_rdata[k],  e_rdata[k][1]);
      if (acc) begin
        chk({s, ".mem_addr"},  mem_addr[k],  t_addr[k]);
        chk({s, ".mem_wdata"}, mem_wdata[k], t_wdata[k]);
      end
      if (cpu_done[k] === 1'b1) done_cnt[k]++;
      if (mem_wr[k] === 1'b1)   wr_cyc[k]++;
    end
    if (track) begin
      if (cpu_gnt[0] === 1'b1 && !prev_gc) seen_q.push_back(1'b0);
      if (ld_gnt[0]  === 1'b1 && !prev_gl) seen_q.push_back(1'b1);
    end
    prev_gc = (cpu_gnt[0] === 1'b1);
    prev_gl = (ld_gnt[0]  === 1'b1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    int dc;
    int wc;
    bit exp_own;

    rst = 1'b1;
    cpu_req = 1'b0; ld_req = 1'b0; cpu_wr = 1'b0; ld_wr = 1'b0;
    cpu_addr = '0; ld_addr = '0; cpu_wdata = '0; ld_wdata = '0;
    cyc = 0; track = 1'b0; prev_gc = 1'b0; prev_gl = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_start[k] = -100; t_wr[k] = 1'b0; t_own[k] = 1'b0; last_ld[k] = 1'b1;
      t_addr[k] = '0; t_wdata[k] = '0; e_rdata[k][0] = '0; e_rdata[k][1] = '0;
      done_cnt[k] = 0; wr_cyc[k] = 0;
      for (int i = 0; i < 32; i++) begin
        logic [DW-1:0] v;
        v = DW'($urandom);
        mem[k][i] = v;
        ref_mem[k][i] = v;
      end
    end

    // Reset state
    step(2);
    chk("rst.cpu_rdata", cpu_rdata[1], 8'h00);
    chk("rst.mem_addr", mem_addr[1], 5'h00);
    rst = 1'b0;
    step(1);

    // Single CPU read, request dropped after the accepting edge
    mem[0][3] = 8'hA5; ref_mem[0][3] = 8'hA5;
    mem[1][3] = 8'hA5; ref_mem[1][3] = 8'hA5;
    dc = done_cnt[1];
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h03;
    step(1);
    chk("rd.cpu_gnt_t1", cpu_gnt[0], 1'b1);
    chk("rd.mem_rd_t1", mem_rd[0], 1'b1);
    cpu_req = 1'b0;
    step(1);
    chk("rd.cpu_done_t2", cpu_done[0], 1'b1);
    chk("rd.cpu_rdata", cpu_rdata[0], 8'hA5);
    step(4);
    chk("rd.cpu_rdata_l3", cpu_rdata[1], 8'hA5);
    chk("drop.done_once", done_cnt[1] - dc, 1);
    chk("drop.no_second", busy[1], 1'b0);

    // Loader write then read-back
    wc = wr_cyc[1];
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 5'h1F; ld_wdata = 8'h3C;
    step(1);
    ld_req = 1'b0; ld_wr = 1'b0;
    step(3);
    chk("wr.ld_done_t4", ld_done[1], 1'b1);
    step(2);
    chk("wr.mem_wr_cycles", wr_cyc[1] - wc, 3);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h1F;
    step(1);
    cpu_req = 1'b0;
    step(5);
    chk("wr.readback_l1", cpu_rdata[0], 8'h3C);
    chk("wr.readback_l3", cpu_rdata[1], 8'h3C);

    // Reset in the second ACCESS cycle of a CPU read
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'h07;
    step(1);
    cpu_req = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    chk("rstmid.mem_rd", mem_rd[1], 1'b0);
    chk("rstmid.busy", busy[1], 1'b0);
    chk("rstmid.cpu_gnt", cpu_gnt[1], 1'b0);
    rst = 1'b0;
    dc = done_cnt[1];
    step(3);
    chk("rstmid.no_done", done_cnt[1] - dc, 0);

    // Tie with both requests held
    cpu_req = 1'b1; ld_req = 1'b1; cpu_wr = 1'b0; ld_wr = 1'b0;
    cpu_addr = 5'h02; ld_addr = 5'h11;
    seen_q.delete();
    track = 1'b1;
    step(4 * (LAT0 + 2));
    track = 1'b0;
    cpu_req = 1'b0; ld_req = 1'b0;
    step(6);
    chk("tie.grant_count", seen_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_LD_PRIO_EN
      exp_own = 1'b1;
`else
      exp_own = (i % 2) == 1;
`endif
      if (i < seen_q.size()) chk($sformatf("tie.grant%0d", i), seen_q[i], exp_own);
    end

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      cpu_req   = ($urandom_range(0, 2) != 0);
      ld_req    = ($urandom_range(0, 2) != 0);
      cpu_wr    = $urandom_range(0, 1) == 1;
      ld_wr     = $urandom_range(0, 1) == 1;
      cpu_addr  = AW'($urandom);
      ld_addr   = AW'($urandom);
      cpu_wdata = DW'($urandom);
      ld_wdata  = DW'($urandom);
      step(1);
    end
    rst = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
    step(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
